// File: rtl/ppu_sprite_render.sv
// Sprite fetch and render stage: loads eight sprite slots from secondary OAM and pattern
// memory during dots 257-320 and shifts out the winning sprite pixel during dots 1-256.
module ppu_sprite_render #(
    parameter int unsigned NUM_SLOTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  x_i,
    input  logic [8:0]  y_i,
    input  logic        spr_enable_i,
    input  logic        spr_left_en_i,
    input  logic        spr_size_16_i,
    input  logic        spr_pt_i,
    input  logic        slot_0_is_spr_0_i,
    output logic [4:0]  sec_oam_addr_o,
    input  logic [7:0]  sec_oam_data_i,
    output logic [13:0] vram_addr_o,
    output logic        vram_rd_o,
    input  logic [7:0]  vram_data_i,
    output logic [3:0]  spr_pixel_o,
    output logic        spr_priority_o,
    output logic        spr_is_spr0_o
);

    logic [7:0] pat_lo_q [NUM_SLOTS];
    logic [7:0] pat_hi_q [NUM_SLOTS];
    logic [7:0] x_cnt_q  [NUM_SLOTS];
    logic       pri_q    [NUM_SLOTS];
    logic [1:0] pal_q    [NUM_SLOTS];
    logic       spr0_q;

    logic [7:0] lat_y_q, lat_tile_q, lat_x_q, lat_lo_q;
    logic       lat_vflip_q, lat_hflip_q, lat_pri_q;
    logic [1:0] lat_pal_q;

    logic [5:0]  fx;
    logic [2:0]  slot_idx, k;
    logic        in_fetch, in_render, show;
    logic [3:0]  row;
    logic [12:0] pat_addr;

    // 257 = 256 + 1, so the low six bits minus one give the window offset directly
    assign fx        = x_i[5:0] - 6'd1;
    assign slot_idx  = fx[5:3];
    assign k         = fx[2:0];
    assign in_fetch  = spr_enable_i && (y_i < 9'd240) && (x_i >= 9'd257) && (x_i <= 9'd320);
    assign in_render = spr_enable_i && (x_i >= 9'd1) && (x_i <= 9'd256);

    assign row      = (y_i[3:0] - lat_y_q[3:0]) ^ {4{lat_vflip_q}};
    assign pat_addr = spr_size_16_i ?
                      {lat_tile_q[0], lat_tile_q[7:1], row[3], k[1], row[2:0]} :
                      {spr_pt_i, lat_tile_q, k[1], row[2:0]};

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    always_comb begin
        sec_oam_addr_o = '0;
        vram_addr_o    = '0;
        vram_rd_o      = 1'b0;
        if (!rst && in_fetch) begin
            if (!k[2]) begin
                sec_oam_addr_o = {slot_idx, k[1:0]};
            end else begin
                vram_addr_o = {1'b0, pat_addr};
                vram_rd_o   = ~k[0];
            end
        end
    end

    logic [3:0] win_pix;
    logic       win_pri, win_s0, found;

    // Lowest-index opaque slot wins
    always_comb begin
        win_pix = '0;
        win_pri = 1'b0;
        win_s0  = 1'b0;
        found   = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!found && x_cnt_q[s] == 8'd0 && (pat_hi_q[s][7] | pat_lo_q[s][7])) begin
                found   = 1'b1;
                win_pix = {pal_q[s], pat_hi_q[s][7], pat_lo_q[s][7]};
                win_pri = pri_q[s];
                win_s0  = (s == 0) && spr0_q;
            end
        end
    end

    assign show           = !rst && in_render && !((x_i <= 9'd8) && !spr_left_en_i);
    assign spr_pixel_o    = show ? win_pix : 4'd0;
    assign spr_priority_o = show && win_pri;
    assign spr_is_spr0_o  = show && win_s0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                pat_lo_q[s] <= '0;
                pat_hi_q[s] <= '0;
                x_cnt_q[s]  <= '0;
                pri_q[s]    <= 1'b0;
                pal_q[s]    <= '0;
            end
            spr0_q      <= 1'b0;
            lat_y_q     <= '0;
            lat_tile_q  <= '0;
            lat_x_q     <= '0;
            lat_lo_q    <= '0;
            lat_vflip_q <= 1'b0;
            lat_hflip_q <= 1'b0;
            lat_pri_q   <= 1'b0;
            lat_pal_q   <= '0;
        end else if (spr_enable_i) begin
            if (in_fetch) begin
                if (x_i == 9'd257) spr0_q <= slot_0_is_spr_0_i;
                case (k)
                    3'd0: lat_y_q    <= sec_oam_data_i;
                    3'd1: lat_tile_q <= sec_oam_data_i;
                    3'd2: begin
                        lat_vflip_q <= sec_oam_data_i[7];
                        lat_hflip_q <= sec_oam_data_i[6];
                        lat_pri_q   <= sec_oam_data_i[5];
                        lat_pal_q   <= sec_oam_data_i[1:0];
                    end
                    3'd3: lat_x_q  <= sec_oam_data_i;
                    3'd5: lat_lo_q <= vram_data_i;
                    3'd7: begin
                        if (lat_y_q == 8'hFF) begin
                            pat_lo_q[slot_idx] <= '0;
                            pat_hi_q[slot_idx] <= '0;
                        end else begin
                            pat_lo_q[slot_idx] <= lat_hflip_q ? rev8(lat_lo_q) : lat_lo_q;
                            pat_hi_q[slot_idx] <= lat_hflip_q ? rev8(vram_data_i) : vram_data_i;
                        end
                        x_cnt_q[slot_idx] <= lat_x_q;
                        pri_q[slot_idx]   <= lat_pri_q;
                        pal_q[slot_idx]   <= lat_pal_q;
                    end
                    default: ;
                endcase
            end else if (x_i == 9'd257 && y_i >= 9'd240) begin
                // Nothing is fetched on these lines, so line 0 must start empty
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    pat_lo_q[s] <= '0;
                    pat_hi_q[s] <= '0;
                end
                spr0_q <= 1'b0;
            end
            if (in_render) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (x_cnt_q[s] != 8'd0) begin
                        x_cnt_q[s] <= x_cnt_q[s] - 8'd1;
                    end else begin
                        pat_lo_q[s] <= {pat_lo_q[s][6:0], 1'b0};
                        pat_hi_q[s] <= {pat_hi_q[s][6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_sprite_render.sv
// Bench for ppu_sprite_render: directed scenarios plus randomized lines checked against a
// per-pixel reference model built from OAM and pattern memory contents.
module tb_ppu_sprite_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  x_i, y_i;
    logic        spr_enable_i, spr_left_en_i, spr_size_16_i, spr_pt_i, slot_0_is_spr_0_i;
    logic [4:0]  sec_oam_addr_o;
    logic [7:0]  sec_oam_data_i;
    logic [13:0] vram_addr_o;
    logic        vram_rd_o;
    logic [7:0]  vram_data_i = 8'h00;
    logic [3:0]  spr_pixel_o;
    logic        spr_priority_o, spr_is_spr0_o;

    logic [7:0] soam [0:31];
    logic [7:0] vmem [0:16383];

    logic [3:0]  o_pix  [0:340];
    logic        o_pri  [0:340];
    logic        o_s0   [0:340];
    logic        o_rd   [0:340];
    logic [13:0] o_addr [0:340];
    logic [4:0]  o_soa  [0:340];

    logic [3:0] e_pix [0:255];
    logic       e_pri [0:255];
    logic       e_s0  [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sec_oam_data_i = soam[sec_oam_addr_o];
    always @(posedge clk) if (vram_rd_o) vram_data_i <= vmem[vram_addr_o];

    ppu_sprite_render #(.NUM_SLOTS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .x_i               (x_i),
        .y_i               (y_i),
        .spr_enable_i      (spr_enable_i),
        .spr_left_en_i     (spr_left_en_i),
        .spr_size_16_i     (spr_size_16_i),
        .spr_pt_i          (spr_pt_i),
        .slot_0_is_spr_0_i (slot_0_is_spr_0_i),
        .sec_oam_addr_o    (sec_oam_addr_o),
        .sec_oam_data_i    (sec_oam_data_i),
        .vram_addr_o       (vram_addr_o),
        .vram_rd_o         (vram_rd_o),
        .vram_data_i       (vram_data_i),
        .spr_pixel_o       (spr_pixel_o),
        .spr_priority_o    (spr_priority_o),
        .spr_is_spr0_o     (spr_is_spr0_o)
    );

    task automatic run_line(input int y, input int xs, input int xe);
        for (int x = xs; x <= xe; x++) begin
            @(negedge clk);
            x_i = 9'(x);
            y_i = 9'(y);
            #1;
            o_pix[x]  = spr_pixel_o;
            o_pri[x]  = spr_priority_o;
            o_s0[x]   = spr_is_spr0_o;
            o_rd[x]   = vram_rd_o;
            o_addr[x] = vram_addr_o;
            o_soa[x]  = sec_oam_addr_o;
        end
    endtask

    task automatic clear_soam();
        for (int i = 0; i < 32; i++) soam[i] = 8'hFF;
    endtask

    task automatic set_slot(input int s, input logic [7:0] yy, input logic [7:0] tile,
                            input logic [7:0] attr, input logic [7:0] xx);
        soam[s*4]   = yy;
        soam[s*4+1] = tile;
        soam[s*4+2] = attr;
        soam[s*4+3] = xx;
    endtask

    // Pattern address derived from the sprite's row within its tile, in plain arithmetic
    function automatic logic [13:0] m_addr(input int s, input int plane, input int yf);
        int yy, tile, r, a;
        logic [7:0] attr;
        yy   = int'(soam[s*4]);
        tile = int'(soam[s*4+1]);
        attr = soam[s*4+2];
        if (!spr_size_16_i) begin
            r = (yf - yy) & 7;
            if (attr[7]) r = 7 - r;
            a = int'(spr_pt_i) * 4096 + tile * 16 + plane * 8 + r;
        end else begin
            r = (yf - yy) & 15;
            if (attr[7]) r = 15 - r;
            a = (tile % 2) * 4096 + (tile / 2) * 32 + (r / 8) * 16 + plane * 8 + r % 8;
        end
        return a[13:0];
    endfunction

    task automatic build_expect(input int yf);
        logic [7:0] lo, hi, attr;
        logic [1:0] c;
        int col, b;
        bit found;
        for (int p = 0; p < 256; p++) begin
            e_pix[p] = 4'd0;
            e_pri[p] = 1'b0;
            e_s0[p]  = 1'b0;
            found    = 1'b0;
            for (int s = 0; s < 8; s++) begin
                attr = soam[s*4+2];
                if (!found && soam[s*4] != 8'hFF) begin
                    col = p - int'(soam[s*4+3]);
                    if (col >= 0 && col < 8) begin
                        lo = vmem[m_addr(s, 0, yf)];
                        hi = vmem[m_addr(s, 1, yf)];
                        b  = attr[6] ? col : 7 - col;
                        c  = {hi[b], lo[b]};
                        if (c != 2'd0) begin
                            found    = 1'b1;
                            e_pix[p] = {attr[1:0], c};
                            e_pri[p] = attr[5];
                            e_s0[p]  = (s == 0) && slot_0_is_spr_0_i;
                        end
                    end
                end
            end
            if (p < 8 && !spr_left_en_i) begin
                e_pix[p] = 4'd0;
                e_pri[p] = 1'b0;
                e_s0[p]  = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        clear_soam();
        set_slot(0, 8'd4, 8'h11, 8'h00, 8'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        x_i = 9'd261; y_i = 9'd5; #1;
        n_checks++;
        if (vram_rd_o !== 1'b0 || vram_addr_o !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_vram: rd=%0b addr=%h required 0/0", vram_rd_o, vram_addr_o);
        end
        @(negedge clk); x_i = 9'd258; #1;
        n_checks++;
        if (sec_oam_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_soam_addr: got %0d required 0", sec_oam_addr_o);
        end
        @(negedge clk); x_i = 9'd21; #1;
        n_checks++;
        if ({spr_pixel_o, spr_priority_o, spr_is_spr0_o} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pixel: got %h/%b/%b required 0", spr_pixel_o, spr_priority_o,
                     spr_is_spr0_o);
        end
        @(negedge clk); rst = 1'b0;
        run_line(30, 0, 256);
        for (int x = 1; x <= 256; x++) begin
            n_checks++;
            if ({o_pix[x], o_pri[x], o_s0[x]} !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_slots x=%0d: got %h required 0", x, o_pix[x]);
            end
        end
    endtask

    task automatic test_basic();
        spr_size_16_i = 1'b0; spr_pt_i = 1'b0; spr_left_en_i = 1'b1; slot_0_is_spr_0_i = 1'b0;
        clear_soam();
        set_slot(0, 8'd10, 8'h21, 8'h01, 8'd20);
        vmem[14'h212] = 8'h80;
        vmem[14'h21A] = 8'h80;
        run_line(12, 0, 340);
        n_checks++;
        if (o_rd[261] !== 1'b1 || o_addr[261] !== 14'h0212) begin
            n_fail++;
            $display("FAIL basic_lo_addr: rd=%0b addr=%h required 1/0212", o_rd[261], o_addr[261]);
        end
        n_checks++;
        if (o_rd[263] !== 1'b1 || o_addr[263] !== 14'h021A) begin
            n_fail++;
            $display("FAIL basic_hi_addr: rd=%0b addr=%h required 1/021A", o_rd[263], o_addr[263]);
        end
        n_checks++;
        if (o_rd[262] !== 1'b0 || o_rd[264] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rd_strobe: k5=%0b k7=%0b required 0/0", o_rd[262], o_rd[264]);
        end
        n_checks++;
        if (o_soa[260] !== 5'd3 || o_soa[266] !== 5'd5) begin
            n_fail++;
            $display("FAIL basic_soam_addr: %0d/%0d required 3/5", o_soa[260], o_soa[266]);
        end
        run_line(13, 0, 256);
        n_checks++;
        if (o_pix[21] !== 4'b0111 || o_pix[20] !== 4'd0 || o_pix[22] !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_pixel: x20=%h x21=%h x22=%h required 0/7/0",
                     o_pix[20], o_pix[21], o_pix[22]);
        end
    endtask

    task automatic test_flip();
        clear_soam();
        set_slot(0, 8'd10, 8'h21, 8'h41, 8'd20);
        vmem[14'h212] = 8'h01;
        vmem[14'h21A] = 8'h01;
        run_line(12, 0, 340);
        run_line(13, 0, 256);
        n_checks++;
        if (o_pix[21] !== 4'b0111 || o_pix[22] !== 4'd0) begin
            n_fail++;
            $display("FAIL hflip_pixel: x21=%h x22=%h required 7/0", o_pix[21], o_pix[22]);
        end
        set_slot(0, 8'd10, 8'h21, 8'h81, 8'd20);
        run_line(12, 0, 340);
        n_checks++;
        if (o_addr[261] !== 14'h0215 || o_addr[263] !== 14'h021D) begin
            n_fail++;
            $display("FAIL vflip_addr: %h/%h required 0215/021D", o_addr[261], o_addr[263]);
        end
        run_line(13, 0, 256);
    endtask

    task automatic test_tall();
        spr_size_16_i = 1'b1;
        clear_soam();
        set_slot(0, 8'd10, 8'h23, 8'h00, 8'd50);
        run_line(19, 0, 340);
        n_checks++;
        if (o_addr[261] !== 14'h1231 || o_addr[263] !== 14'h1239) begin
            n_fail++;
            $display("FAIL tall_addr: %h/%h required 1231/1239", o_addr[261], o_addr[263]);
        end
        set_slot(0, 8'd10, 8'h23, 8'h80, 8'd50);
        run_line(19, 0, 340);
        n_checks++;
        if (o_addr[261] !== 14'h1226 || o_addr[263] !== 14'h122E) begin
            n_fail++;
            $display("FAIL tall_vflip_addr: %h/%h required 1226/122E", o_addr[261], o_addr[263]);
        end
        run_line(20, 0, 256);
        spr_size_16_i = 1'b0;
    endtask

    task automatic test_overlap();
        clear_soam();
        slot_0_is_spr_0_i = 1'b1;
        set_slot(0, 8'd10, 8'h30, 8'h00, 8'd40);
        set_slot(1, 8'd10, 8'h31, 8'h22, 8'd40);
        vmem[14'h302] = 8'h00; vmem[14'h30A] = 8'h00;
        vmem[14'h312] = 8'hFF; vmem[14'h31A] = 8'h00;
        run_line(12, 0, 340);
        run_line(13, 0, 256);
        n_checks++;
        if (o_pix[41] !== 4'h9 || o_pri[41] !== 1'b1 || o_s0[41] !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_slot1: pix=%h pri=%b s0=%b required 9/1/0",
                     o_pix[41], o_pri[41], o_s0[41]);
        end
        vmem[14'h302] = 8'hFF; vmem[14'h30A] = 8'hFF;
        run_line(12, 0, 340);
        build_expect(12);
        run_line(13, 0, 256);
        n_checks++;
        if (o_pix[41] !== 4'h3 || o_pri[41] !== 1'b0 || o_s0[41] !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_slot0: pix=%h pri=%b s0=%b required 3/0/1",
                     o_pix[41], o_pri[41], o_s0[41]);
        end
        for (int p = 0; p < 256; p++) begin
            n_checks++;
            if ({o_pix[p+1], o_pri[p+1], o_s0[p+1]} !== {e_pix[p], e_pri[p], e_s0[p]}) begin
                n_fail++;
                $display("FAIL overlap_line x=%0d: got %h/%b/%b required %h/%b/%b", p + 1,
                         o_pix[p+1], o_pri[p+1], o_s0[p+1], e_pix[p], e_pri[p], e_s0[p]);
            end
        end
        slot_0_is_spr_0_i = 1'b0;
    endtask

    task automatic test_empty_left();
        int bad;
        clear_soam();
        run_line(100, 0, 340);
        run_line(101, 0, 256);
        bad = 0;
        for (int x = 1; x <= 256; x++) if (o_pix[x] !== 4'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL empty_slots: %0d opaque dots required 0", bad);
        end
        set_slot(0, 8'd10, 8'h40, 8'h00, 8'd0);
        vmem[14'h402] = 8'hFF; vmem[14'h40A] = 8'hFF;
        spr_left_en_i = 1'b0;
        run_line(12, 0, 340);
        run_line(13, 0, 256);
        bad = 0;
        for (int x = 1; x <= 9; x++) if (o_pix[x] !== 4'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL left_mask: %0d opaque dots in 1..9 required 0", bad);
        end
        spr_left_en_i = 1'b1;
        run_line(12, 0, 340);
        run_line(13, 0, 256);
        bad = 0;
        for (int x = 1; x <= 8; x++) if (o_pix[x] !== 4'h3) bad++;
        n_checks++;
        if (bad != 0 || o_pix[9] !== 4'd0) begin
            n_fail++;
            $display("FAIL left_shown: %0d wrong dots in 1..8, x9=%h required 0/0", bad, o_pix[9]);
        end
    endtask

    task automatic test_disable();
        int bad;
        clear_soam();
        set_slot(2, 8'd60, 8'h45, 8'h03, 8'd77);
        vmem[14'h453] = 8'hA5; vmem[14'h45B] = 8'h3C;
        run_line(63, 0, 340);
        build_expect(63);
        spr_enable_i = 1'b0;
        run_line(64, 0, 340);
        bad = 0;
        for (int x = 0; x <= 340; x++) if (o_pix[x] !== 4'd0 || o_rd[x] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL disable_outputs: %0d active dots required 0", bad);
        end
        spr_enable_i = 1'b1;
        run_line(64, 0, 256);
        for (int p = 70; p < 90; p++) begin
            n_checks++;
            if (o_pix[p+1] !== e_pix[p]) begin
                n_fail++;
                $display("FAIL disable_frozen x=%0d: got %h required %h", p + 1, o_pix[p+1], e_pix[p]);
            end
        end
    endtask

    task automatic test_nonrender();
        int bad;
        clear_soam();
        set_slot(0, 8'd50, 8'h12, 8'h00, 8'd100);
        vmem[14'h122] = 8'hFF; vmem[14'h12A] = 8'hFF;
        run_line(52, 0, 340);
        run_line(245, 257, 340);
        bad = 0;
        for (int x = 257; x <= 340; x++) if (o_rd[x] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nonrender_fetch: %0d strobes required 0", bad);
        end
        run_line(0, 0, 256);
        bad = 0;
        for (int x = 1; x <= 256; x++) if (o_pix[x] !== 4'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL nonrender_clear: %0d opaque dots on line 0 required 0", bad);
        end
    endtask

    task automatic test_reset_midfetch();
        int bad;
        clear_soam();
        set_slot(0, 8'd20, 8'h50, 8'h00, 8'd30);
        vmem[14'h502] = 8'hFF; vmem[14'h50A] = 8'hFF;
        run_line(22, 0, 270);
        @(negedge clk); rst = 1'b1; x_i = 9'd271;
        @(negedge clk); rst = 1'b0;
        run_line(23, 0, 256);
        bad = 0;
        for (int x = 1; x <= 256; x++) if (o_pix[x] !== 4'd0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midfetch_stale: %0d opaque dots required 0", bad);
        end
        run_line(22, 0, 340);
        n_checks++;
        if (o_addr[261] !== 14'h0502) begin
            n_fail++;
            $display("FAIL midfetch_refetch_addr: %h required 0502", o_addr[261]);
        end
        run_line(23, 0, 256);
        n_checks++;
        if (o_pix[31] !== 4'h3 || o_pix[38] !== 4'h3 || o_pix[39] !== 4'h0) begin
            n_fail++;
            $display("FAIL midfetch_pixel: x31=%h x38=%h x39=%h required 3/3/0",
                     o_pix[31], o_pix[38], o_pix[39]);
        end
    endtask

    task automatic test_random();
        int yf;
        for (int it = 0; it < 20; it++) begin
            spr_size_16_i     = 1'($urandom);
            spr_pt_i          = 1'($urandom);
            spr_left_en_i     = 1'($urandom);
            slot_0_is_spr_0_i = 1'($urandom);
            yf = int'($urandom_range(0, 238));
            for (int s = 0; s < 8; s++) begin
                if ($urandom_range(0, 3) == 0) soam[s*4] = 8'hFF;
                else soam[s*4] = 8'(yf - int'($urandom_range(0, spr_size_16_i ? 15 : 7)));
                soam[s*4+1] = 8'($urandom);
                soam[s*4+2] = 8'($urandom);
                soam[s*4+3] = 8'($urandom);
            end
            run_line(yf, 0, 340);
            for (int s = 0; s < 8; s++) begin
                n_checks++;
                if (o_rd[261+8*s] !== 1'b1 || o_addr[261+8*s] !== m_addr(s, 0, yf) ||
                    o_rd[263+8*s] !== 1'b1 || o_addr[263+8*s] !== m_addr(s, 1, yf)) begin
                    n_fail++;
                    $display("FAIL rand_fetch it=%0d slot=%0d: %h/%h required %h/%h", it, s,
                             o_addr[261+8*s], o_addr[263+8*s], m_addr(s, 0, yf), m_addr(s, 1, yf));
                end
            end
            n_checks++;
            if (o_pix[300] !== 4'd0 || o_soa[259+8*3] !== 5'd14) begin
                n_fail++;
                $display("FAIL rand_window it=%0d: pix=%h soam=%0d required 0/14", it,
                         o_pix[300], o_soa[259+8*3]);
            end
            build_expect(yf);
            run_line(yf + 1, 0, 256);
            n_checks++;
            if (o_pix[0] !== 4'd0) begin
                n_fail++;
                $display("FAIL rand_dot0 it=%0d: got %h required 0", it, o_pix[0]);
            end
            for (int p = 0; p < 256; p++) begin
                n_checks++;
                if ({o_pix[p+1], o_pri[p+1], o_s0[p+1]} !== {e_pix[p], e_pri[p], e_s0[p]}) begin
                    n_fail++;
                    $display("FAIL rand_pixel it=%0d x=%0d: got %h/%b/%b required %h/%b/%b", it,
                             p + 1, o_pix[p+1], o_pri[p+1], o_s0[p+1], e_pix[p], e_pri[p], e_s0[p]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        x_i = '0;
        y_i = '0;
        spr_enable_i = 1'b1;
        spr_left_en_i = 1'b1;
        spr_size_16_i = 1'b0;
        spr_pt_i = 1'b0;
        slot_0_is_spr_0_i = 1'b0;
        for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
        clear_soam();
        test_reset();
        test_basic();
        test_flip();
        test_tall();
        test_overlap();
        test_empty_left();
        test_disable();
        test_nonrender();
        test_reset_midfetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
